fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_ctrl.sv | 71 +++++++
 tb/tb_fetch_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-controller definitions: FSM encoding, address type and reset vector default.
// Imported by the interface, the controller and its bench.
package fetch_ctrl_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam addr_t RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bundle: hazard/branch inputs, instruction-memory request/ready, IF/ID outputs.
// The master side is the fetch controller; the slave side is the pipeline/memory environment.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic  stall;
    logic  br_valid;
    logic  br_taken;
    addr_t br_target;
    logic  imem_req;
    addr_t imem_addr;
    logic  imem_ready;
    logic  if_valid;
    addr_t if_pc;
    logic [31:0] redir_cnt;

    modport master (
        input  stall, br_valid, br_taken, br_target, imem_ready,
        output imem_req, imem_addr, if_valid, if_pc, redir_cnt
    );

    modport slave (
        output stall, br_valid, br_taken, br_target, imem_ready,
        input  imem_req, imem_addr, if_valid, if_pc, redir_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch PC controller with one branch delay slot; if_valid/if_pc are combinational (0-cycle) on completion.
// Backpressure: imem_ready=0 or stall=1 holds the request and pc; a taken branch during a wait is parked until the slot completes.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);

    state_t      r_state;
    addr_t       r_pc;
    addr_t       r_pend_tgt;
    logic        r_req;
    logic [31:0] r_redir_cnt;

    logic w_done;
    logic w_br_take;

    assign w_done    = r_req & bus.imem_ready & ~bus.stall;
    assign w_br_take = bus.br_valid & bus.br_taken & ~bus.stall;

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = w_done;
    assign bus.if_pc     = r_pc;
    assign bus.redir_cnt = r_redir_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= BOOT;
            r_pc        <= RESET_PC;
            r_pend_tgt  <= '0;
            r_req       <= 1'b0;
            r_redir_cnt <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    r_req   <= 1'b1;
                end
                RUN: begin
                    // The fetch in flight is the delay slot; redirect only once it has completed.
                    if (w_br_take && w_done) begin
                        r_pc        <= bus.br_target;
                        r_redir_cnt <= r_redir_cnt + 32'd1;
                    end else if (w_br_take) begin
                        r_pend_tgt <= bus.br_target;
                        r_state    <= PEND;
                    end else if (w_done) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                PEND: begin
                    if (w_done) begin
                        r_pc        <= r_pend_tgt;
                        r_redir_cnt <= r_redir_cnt + 32'd1;
                        r_state     <= RUN;
                    end
                end
                default: begin
                    r_state <= BOOT;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed delay-slot/stall/wrap/reset cases, then random traffic,
// all checked against a redirect-queue model of the fetch stream.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(RESET_PC_DEF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Model: fetch address stream plus at most one outstanding redirect (first target wins).
    addr_t       m_pc;
    logic [31:0] m_cnt;
    bit          m_live;
    addr_t       m_redir[$];

    logic        obs_vld;
    addr_t       obs_pc;
    logic [31:0] obs_cnt;

    task automatic m_reset();
        m_pc   = RESET_PC_DEF;
        m_cnt  = '0;
        m_live = 1'b0;
        m_redir.delete();
    endtask

    // One clock: apply inputs, compare at negedge, advance model, return at posedge+1.
    task automatic cyc(input logic s, input logic bv, input logic bt, input addr_t tg, input logic rd);
        logic exp_done;
        bus.stall      = s;
        bus.br_valid   = bv;
        bus.br_taken   = bt;
        bus.br_target  = tg;
        bus.imem_ready = rd;
        @(negedge clk);
        exp_done = m_live && rd && !s;
        check_eq("imem_req",  {31'd0, bus.imem_req}, {31'd0, m_live});
        check_eq("if_valid",  {31'd0, bus.if_valid}, {31'd0, exp_done});
        check_eq("imem_addr", bus.imem_addr, m_pc);
        check_eq("if_pc",     bus.if_pc, m_pc);
        check_eq("redir_cnt", bus.redir_cnt, m_cnt);
        obs_vld = bus.if_valid;
        obs_pc  = bus.if_pc;
        obs_cnt = bus.redir_cnt;
        if (!m_live) begin
            m_live = 1'b1;
        end else if (!s) begin
            if (bv && bt && m_redir.size() == 0) m_redir.push_back(tg);
            if (rd) begin
                if (m_redir.size() != 0) begin
                    m_pc = m_redir.pop_front();
                    m_cnt++;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.stall = 1'b0; bus.br_valid = 1'b0; bus.br_taken = 1'b0;
        bus.br_target = '0; bus.imem_ready = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req",  {31'd0, bus.imem_req}, 32'd0);
        check_eq("rst_vld",  {31'd0, bus.if_valid}, 32'd0);
        check_eq("rst_addr", bus.imem_addr, 32'h0);
        check_eq("rst_cnt",  bus.redir_cnt, 32'd0);
        rst_n = 1'b1;

        // Sequential fetch, then a taken branch whose delay slot completes immediately.
        cyc(0, 0, 0, 0, 1);
        check_eq("boot_vld", {31'd0, obs_vld}, 32'd0);
        cyc(0, 0, 0, 0, 1);  check_eq("seq0", obs_pc, 32'h0);
        cyc(0, 0, 0, 0, 1);  check_eq("seq4", obs_pc, 32'h4);
        cyc(0, 1, 1, 32'h100, 1);
        check_eq("slot8", obs_pc, 32'h8);
        check_eq("slot8_vld", {31'd0, obs_vld}, 32'd1);
        cyc(0, 0, 0, 0, 1);
        check_eq("tgt100", obs_pc, 32'h100);
        check_eq("cnt1", obs_cnt, 32'd1);

        // Branch during a memory wait parks the target; a second branch is ignored.
        cyc(0, 1, 1, 32'h200, 0);
        check_eq("wait_vld", {31'd0, obs_vld}, 32'd0);
        cyc(0, 1, 1, 32'h300, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h400, 1);
        check_eq("slot104", obs_pc, 32'h104);
        cyc(0, 0, 0, 0, 1);
        check_eq("tgt200", obs_pc, 32'h200);
        check_eq("cnt2", obs_cnt, 32'd2);

        // Stall holds pc and blocks the branch.
        cyc(0, 1, 1, 32'h10, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 32'h500, 1);
            check_eq("stall_vld", {31'd0, obs_vld}, 32'd0);
            check_eq("stall_pc",  obs_pc, 32'h10);
            check_eq("stall_cnt", obs_cnt, 32'd3);
        end
        cyc(0, 0, 0, 0, 1);  check_eq("post_stall", obs_pc, 32'h10);
        cyc(0, 0, 0, 0, 1);  check_eq("no_br", obs_pc, 32'h14);

        // Address wrap.
        cyc(0, 1, 1, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 0, 0, 1);  check_eq("top", obs_pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 1);  check_eq("wrap", obs_pc, 32'h0);

        // Reset while a redirect is pending.
        cyc(0, 1, 1, 32'h700, 0);
        rst_n = 1'b0;
        #1;
        check_eq("arst_req", {31'd0, bus.imem_req}, 32'd0);
        check_eq("arst_cnt", bus.redir_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check_eq("rst_pend_pc",  obs_pc, RESET_PC_DEF);
        check_eq("rst_pend_cnt", obs_cnt, 32'd0);
        cyc(0, 0, 0, 0, 1);  check_eq("rst_pend_next", obs_pc, 32'h4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
